// File: rtl/uart_transmitter_pkg.sv
// Shared project definitions for the UART transmitter: logic-level names,
// the frame state enum and the baud divisor calculation.
package uart_transmitter_pkg;

    localparam logic YES  = 1'b1;
    localparam logic NO   = 1'b0;
    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    // Rounds to the nearest whole number of clocks per serial bit.
    function automatic int calcDivisor(input int clockHz, input int baud);
        return (clockHz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with an inline baud counter. A byte requested during
// the last stop-bit cycle starts immediately, so consecutive frames are gapless.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLOCK_HZ = 50000000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       request,
    input  logic [7:0] data,
    output logic       taken,
    output logic       tx,
    output logic       busy
);

    localparam int DIVISOR = calcDivisor(CLOCK_HZ, BAUD);
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DIVISOR - 1);

    if (DIVISOR < 2) begin : g_badDivisor
        $fatal(1, "uart_transmitter: DIVISOR must be at least 2");
    end

    tx_state_t        r_state   = IDLE;
    logic [CNT_W-1:0] r_baudCnt = '0;
    logic [2:0]       r_bitIdx  = '0;
    logic [7:0]       r_shift   = '0;
    logic             r_tx      = HIGH;
    logic             r_taken   = NO;

    tx_state_t        w_nextState;
    logic [CNT_W-1:0] w_nextBaudCnt;
    logic [2:0]       w_nextBitIdx;
    logic [7:0]       w_nextShift;
    logic             w_nextTx;
    logic             w_nextTaken;
    logic             w_lastBaud;
    logic             w_accept;

    assign w_lastBaud = (r_baudCnt == LAST_COUNT);

    always_comb begin
        w_nextState   = r_state;
        w_nextBaudCnt = w_lastBaud ? '0 : r_baudCnt + 1'b1;
        w_nextBitIdx  = r_bitIdx;
        w_nextShift   = r_shift;
        w_nextTx      = r_tx;
        w_nextTaken   = NO;
        w_accept      = NO;

        case (r_state)
            IDLE: begin
                w_nextBaudCnt = '0;
                w_nextTx      = HIGH;
                w_accept      = request;
            end
            START: begin
                if (w_lastBaud) begin
                    w_nextState = DATA;
                    w_nextTx    = r_shift[0];
                end
            end
            DATA: begin
                if (w_lastBaud) begin
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = STOP;
                        w_nextTx    = HIGH;
                    end else begin
                        w_nextBitIdx = r_bitIdx + 3'd1;
                        w_nextShift  = {1'b0, r_shift[7:1]};
                        w_nextTx     = r_shift[1];
                    end
                end
            end
            STOP: begin
                // Accepting here instead of returning to IDLE removes the idle gap.
                if (w_lastBaud) begin
                    w_nextState = IDLE;
                    w_nextTx    = HIGH;
                    w_accept    = request;
                end
            end
            default: w_nextState = IDLE;
        endcase

        if (w_accept) begin
            w_nextState   = START;
            w_nextShift   = data;
            w_nextTaken   = YES;
            w_nextTx      = LOW;
            w_nextBaudCnt = '0;
            w_nextBitIdx  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_tx      <= HIGH;
            r_taken   <= NO;
        end else begin
            r_state   <= w_nextState;
            r_baudCnt <= w_nextBaudCnt;
            r_bitIdx  <= w_nextBitIdx;
            r_shift   <= w_nextShift;
            r_tx      <= w_nextTx;
            r_taken   <= w_nextTaken;
        end
    end

    assign tx    = r_tx;
    assign taken = r_taken;
    assign busy  = (r_state != IDLE);

endmodule
